// File: rtl/multicycle_sequencer_if.sv
// Execute-side request/response bus of the multicycle sequencer.
interface multicycle_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic [1:0]       req_unit;
  logic [TAG_W-1:0] req_tag;
  logic [XLEN-1:0]  req_rdata1;
  logic [XLEN-1:0]  req_rdata2;
  logic             clear;
  logic             stall;
  logic             busy;
  logic             resp_valid;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  resp_data;

  modport master (
    output req_valid, req_unit, req_tag, req_rdata1, req_rdata2, clear,
    input  stall, busy, resp_valid, resp_tag, resp_data
  );

  modport slave (
    input  req_valid, req_unit, req_tag, req_rdata1, req_rdata2, clear,
    output stall, busy, resp_valid, resp_tag, resp_data
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Issues one operation at a time to the divider / multiplier / clmul units and returns the tagged result.
// Optional watchdog on WAIT/DRAIN enabled by defining MCS_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int XLEN           = 32,
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_sequencer_if.slave exe,
  output logic [XLEN-1:0]      op_rdata1,
  output logic [XLEN-1:0]      op_rdata2,
  output logic                 div_enable,
  output logic                 mul_enable,
  output logic                 clmul_enable,
  input  logic                 div_ready,
  input  logic [XLEN-1:0]      div_result,
  input  logic                 mul_ready,
  input  logic [XLEN-1:0]      mul_result,
  input  logic                 clmul_ready,
  input  logic [XLEN-1:0]      clmul_result,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t           state, state_next;
  logic [1:0]       unit_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  rdata1_q, rdata2_q, result_q;
  logic             accept;
  logic             sel_ready;
  logic [XLEN-1:0]  sel_result;
  logic             timeout_hit;
  logic             stall_c, resp_valid_c;

  assign accept = exe.req_valid & ~exe.clear & (exe.req_unit != 2'd3);

  always_comb begin
    sel_ready  = 1'b0;
    sel_result = '0;
    case (unit_q)
      2'd0:    begin sel_ready = div_ready;   sel_result = div_result;   end
      2'd1:    begin sel_ready = mul_ready;   sel_result = mul_result;   end
      2'd2:    begin sel_ready = clmul_ready; sel_result = clmul_result; end
      default: begin sel_ready = 1'b0;        sel_result = '0;           end
    endcase
  end

`ifdef MCS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;

  // Restarts on every entry into WAIT or DRAIN, including WAIT -> DRAIN.
  always_ff @(posedge clk) begin
    if (!rst)
      wait_cnt <= '0;
    else if ((state_next != state) && (state_next == WAIT || state_next == DRAIN))
      wait_cnt <= '0;
    else if (state == WAIT || state == DRAIN)
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    stall_c      = 1'b0;
    resp_valid_c = 1'b0;
    div_enable   = 1'b0;
    mul_enable   = 1'b0;
    clmul_enable = 1'b0;
    timeout_err  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_c    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        stall_c = 1'b1;
        if (exe.clear) begin
          state_next = IDLE;
        end else begin
          div_enable   = (unit_q == 2'd0);
          mul_enable   = (unit_q == 2'd1);
          clmul_enable = (unit_q == 2'd2);
          state_next   = WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (sel_ready) begin
          state_next = exe.clear ? IDLE : DONE;
        end else if (timeout_hit) begin
          timeout_err = 1'b1;
          state_next  = IDLE;
        end else if (exe.clear) begin
          state_next = DRAIN;
        end
      end
      DONE: begin
        resp_valid_c = ~exe.clear;
        state_next   = IDLE;
      end
      DRAIN: begin
        stall_c = 1'b1;
        if (sel_ready) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          timeout_err = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      unit_q   <= '0;
      tag_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept) begin
        unit_q   <= exe.req_unit;
        tag_q    <= exe.req_tag;
        rdata1_q <= exe.req_rdata1;
        rdata2_q <= exe.req_rdata2;
      end
      if (state == WAIT && sel_ready && !exe.clear)
        result_q <= sel_result;
    end
  end

  assign exe.stall      = stall_c;
  assign exe.busy       = (state != IDLE);
  assign exe.resp_valid = resp_valid_c;
  assign exe.resp_tag   = tag_q;
  assign exe.resp_data  = result_q;
  assign op_rdata1      = rdata1_q;
  assign op_rdata2      = rdata2_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle control tables plus data/tag checks.
module tb_multicycle_sequencer;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      op_rdata1, op_rdata2;
  logic             div_enable, mul_enable, clmul_enable;
  logic             div_ready, mul_ready, clmul_ready;
  logic [31:0]      div_result, mul_result, clmul_result;
  logic             timeout_err;
  logic [6:0]       obs;
  int               vectors = 0;
  int               errors  = 0;

  multicycle_sequencer_if #(.XLEN(32), .TAG_W(5)) exe ();

  multicycle_sequencer #(.XLEN(32), .TAG_W(5), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe          (exe.slave),
    .op_rdata1    (op_rdata1),
    .op_rdata2    (op_rdata2),
    .div_enable   (div_enable),
    .mul_enable   (mul_enable),
    .clmul_enable (clmul_enable),
    .div_ready    (div_ready),
    .div_result   (div_result),
    .mul_ready    (mul_ready),
    .mul_result   (mul_result),
    .clmul_ready  (clmul_ready),
    .clmul_result (clmul_result),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // {timeout_err, stall, busy, resp_valid, div_enable, mul_enable, clmul_enable}
  assign obs = {timeout_err, exe.stall, exe.busy, exe.resp_valid, div_enable, mul_enable, clmul_enable};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exe.req_valid  = 1'b0;
    exe.req_unit   = 2'd0;
    exe.req_tag    = '0;
    exe.req_rdata1 = '0;
    exe.req_rdata2 = '0;
    exe.clear      = 1'b0;
    div_ready      = 1'b0;
    mul_ready      = 1'b0;
    clmul_ready    = 1'b0;
    div_result     = 32'hdead_0001;
    mul_result     = 32'hdead_0002;
    clmul_result   = 32'hdead_0003;
  endtask

  task automatic test_reset();
    logic [6:0] exp_tbl [5] = '{7'b0100000, 7'b0110100, 7'b0110000, 7'b0000000, 7'b0000000};
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    vectors++;
    if ({obs, op_rdata1, op_rdata2, exe.resp_data, exe.resp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_state got ctrl=%b op1=%h op2=%h data=%h tag=%h exp all zero",
               obs, op_rdata1, op_rdata2, exe.resp_data, exe.resp_tag);
    end
    rst = 1'b1;
    next_cycle();
    // Reset in WAIT must abandon the op; a late ready must not revive it.
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0);
      exe.req_tag    = 5'd5;
      exe.req_rdata1 = 32'd11;
      exe.req_rdata2 = 32'd22;
      rst            = (c != 2);
      div_ready      = (c == 4);
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL reset_midop cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      if (c == 3) begin
        vectors++;
        if ({op_rdata1, exe.resp_tag} !== '0) begin
          errors++;
          $display("FAIL reset_midop_regs got op1=%h tag=%h exp 0", op_rdata1, exe.resp_tag);
        end
      end
      next_cycle();
    end
    rst = 1'b1;
  endtask

  task automatic test_div();
    logic [6:0] exp_tbl [8] = '{7'b0100000, 7'b0110100, 7'b0110000, 7'b0110000,
                                7'b0110000, 7'b0110000, 7'b0011000, 7'b0000000};
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0);
      exe.req_unit   = 2'd0;
      exe.req_tag    = 5'd7;
      exe.req_rdata1 = 32'd100;
      exe.req_rdata2 = 32'd7;
      div_ready      = (c == 5);
      div_result     = (c == 5) ? 32'd14 : 32'hdead_beef;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL div_ctrl cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      if (c == 1) begin
        vectors++;
        if ({op_rdata1, op_rdata2} !== {32'd100, 32'd7}) begin
          errors++;
          $display("FAIL div_operands got %0d,%0d exp 100,7", op_rdata1, op_rdata2);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({exe.resp_data, exe.resp_tag} !== {32'd14, 5'd7}) begin
          errors++;
          $display("FAIL div_resp got data=%0d tag=%0d exp data=14 tag=7", exe.resp_data, exe.resp_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mul();
    logic [6:0] exp_tbl [5] = '{7'b0100000, 7'b0110010, 7'b0110000, 7'b0011000, 7'b0000000};
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0);
      exe.req_unit   = 2'd1;
      exe.req_tag    = 5'd3;
      exe.req_rdata1 = 32'h0001_0000;
      exe.req_rdata2 = 32'h0000_0010;
      mul_ready      = (c == 2);
      mul_result     = (c == 2) ? 32'h0010_0000 : 32'hdead_beef;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL mul_ctrl cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      if (c == 3) begin
        vectors++;
        if ({exe.resp_data, exe.resp_tag} !== {32'h0010_0000, 5'd3}) begin
          errors++;
          $display("FAIL mul_resp got data=%h tag=%0d exp data=00100000 tag=3", exe.resp_data, exe.resp_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_clmul_drain();
    logic [6:0] exp_tbl [11] = '{7'b0100000, 7'b0110001, 7'b0110000, 7'b0110000, 7'b0110000,
                                 7'b0110000, 7'b0100000, 7'b0110010, 7'b0110000, 7'b0011000,
                                 7'b0000000};
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0) || (c == 6);
      exe.req_unit   = (c < 6) ? 2'd2 : 2'd1;
      exe.req_tag    = (c < 6) ? 5'd9 : 5'd4;
      exe.req_rdata1 = (c < 6) ? 32'h55 : 32'd3;
      exe.req_rdata2 = (c < 6) ? 32'h33 : 32'd5;
      exe.clear      = (c == 2);
      clmul_ready    = (c == 5);
      clmul_result   = 32'h0000_0aaa;
      mul_ready      = (c == 8);
      mul_result     = (c == 8) ? 32'd15 : 32'hdead_beef;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL drain_ctrl cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      if (c == 9) begin
        vectors++;
        if ({exe.resp_data, exe.resp_tag} !== {32'd15, 5'd4}) begin
          errors++;
          $display("FAIL drain_next_resp got data=%0d tag=%0d exp data=15 tag=4", exe.resp_data, exe.resp_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_clear_and_reserved();
    logic [6:0] exp_tbl [4] = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      exe.req_valid = (c == 0) || (c == 2);
      exe.clear     = (c == 0);
      exe.req_unit  = (c == 2) ? 2'd3 : 2'd0;
      exe.req_tag   = 5'd1;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL clear_reserved cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_spurious_ready();
    logic [6:0] exp_tbl [8] = '{7'b0100000, 7'b0110100, 7'b0110000, 7'b0110000,
                                7'b0110000, 7'b0110000, 7'b0011000, 7'b0000000};
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0);
      exe.req_unit   = 2'd0;
      exe.req_tag    = 5'd2;
      exe.req_rdata1 = (c == 0) ? 32'd9 : 32'hffff_ffff;
      exe.req_rdata2 = (c == 0) ? 32'd3 : 32'hffff_ffff;
      mul_ready      = (c == 2) || (c == 3);
      clmul_ready    = (c == 3);
      div_ready      = (c == 5);
      div_result     = (c == 5) ? 32'd3 : 32'hdead_beef;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL spurious_ctrl cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      if (c == 4) begin
        vectors++;
        if ({op_rdata1, op_rdata2} !== {32'd9, 32'd3}) begin
          errors++;
          $display("FAIL operand_hold got %h,%h exp 9,3", op_rdata1, op_rdata2);
        end
      end
      if (c == 6) begin
        vectors++;
        if ({exe.resp_data, exe.resp_tag} !== {32'd3, 5'd2}) begin
          errors++;
          $display("FAIL spurious_resp got data=%0d tag=%0d exp data=3 tag=2", exe.resp_data, exe.resp_tag);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_clear_issue_done();
    logic [6:0] exp_tbl [8] = '{7'b0100000, 7'b0110000, 7'b0000000, 7'b0100000,
                                7'b0110010, 7'b0110000, 7'b0010000, 7'b0000000};
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      exe.req_valid  = (c == 0) || (c == 3);
      exe.req_unit   = (c < 3) ? 2'd0 : 2'd1;
      exe.req_tag    = 5'd6;
      exe.req_rdata1 = 32'd2;
      exe.req_rdata2 = 32'd2;
      exe.clear      = (c == 1) || (c == 6);
      mul_ready      = (c == 5);
      mul_result     = 32'd4;
      #1;
      vectors++;
      if (obs !== exp_tbl[c]) begin
        errors++;
        $display("FAIL clear_issue_done cycle %0d got %b exp %b", c, obs, exp_tbl[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp_c;
`ifdef MCS_TIMEOUT_EN
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      exe.req_valid = (c == 0);
      exe.req_tag   = 5'd8;
      exp_c = (c == 0) ? 7'b0100000 :
              (c == 1) ? 7'b0110100 :
              (c == 9) ? 7'b1110000 :
              (c == 10) ? 7'b0000000 : 7'b0110000;
      #1;
      vectors++;
      if (obs !== exp_c) begin
        errors++;
        $display("FAIL timeout_ctrl cycle %0d got %b exp %b", c, obs, exp_c);
      end
      next_cycle();
    end
`else
    for (int c = 0; c < 23; c++) begin
      idle_inputs();
      exe.req_valid = (c == 0);
      exe.req_tag   = 5'd8;
      div_ready     = (c == 20);
      div_result    = (c == 20) ? 32'h1234_5678 : 32'hdead_beef;
      exp_c = (c == 0) ? 7'b0100000 :
              (c == 1) ? 7'b0110100 :
              (c == 21) ? 7'b0011000 :
              (c == 22) ? 7'b0000000 : 7'b0110000;
      #1;
      vectors++;
      if (obs !== exp_c) begin
        errors++;
        $display("FAIL long_wait_ctrl cycle %0d got %b exp %b", c, obs, exp_c);
      end
      if (c == 21) begin
        vectors++;
        if ({exe.resp_data, exe.resp_tag} !== {32'h1234_5678, 5'd8}) begin
          errors++;
          $display("FAIL long_wait_resp got data=%h tag=%0d exp data=12345678 tag=8", exe.resp_data, exe.resp_tag);
        end
      end
      next_cycle();
    end
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #1;
    test_reset();
    test_div();
    test_mul();
    test_clmul_drain();
    test_clear_and_reserved();
    test_spurious_ready();
    test_clear_issue_done();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
